nco_coff_gen: RTL

- Two-carrier numerically controlled oscillator. It produces the per-sample sin/cos coefficients that multi_freq consumes.
- It sits directly upstream of multi_freq. It forwards the I/Q stream together with coefficients aligned to each sample, so the multiplier needs no local phase state.
- Carriers are time-interleaved and selected per sample by i_data_ca. Each carrier has its own phase accumulator and frequency word.

---
 rtl/nco_pkg.sv | 36 +++
 rtl/nco_quarter_rom.sv | 39 +++
 rtl/nco_coff_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared constants and the quarter-wave table generator for the two-carrier NCO.
package nco_pkg;

  localparam int NCO_LUT_AW   = 10;
  localparam int NCO_COFF_W   = 16;
  localparam int NCO_QTR_AW   = NCO_LUT_AW - 2;
  localparam int NCO_QTR_DEPTH = 1 << NCO_QTR_AW;

  // Quadrant encoding: bit 0 mirrors the table address, bit 1 negates the value.
  localparam int QUAD_MIRROR_BIT = 0;
  localparam int QUAD_NEG_BIT    = 1;

  localparam real NCO_PI = 3.14159265358979323846;

  // Elaboration-time sine via Taylor series, so the table needs no math library.
  // Angle stays within [0, pi/2], where 13 terms are far below one LSB of error.
  function automatic real nco_sin(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / $itor((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // T[k] = round(32767 * sin(2*pi*(k+0.5)/2^lut_aw)); always positive in the first quadrant.
  function automatic int quarter_sample(input int k, input int lut_aw);
    real ang;
    ang = 2.0 * NCO_PI * ($itor(k) + 0.5) / $itor(1 << lut_aw);
    return $rtoi(32767.0 * nco_sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Two-read-port synchronous quarter-wave ROM: addr -> T[addr], registered.
module nco_quarter_rom
  import nco_pkg::*;
#(
  parameter int AW = NCO_QTR_AW,
  parameter int DW = NCO_COFF_W
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  output logic [DW-1:0] data0_o,
  output logic [DW-1:0] data1_o
);

  logic [DW-1:0] rom_w [1 << AW];
  logic [DW-1:0] data0_q, data1_q;

  // Table contents are constants folded at elaboration.
  for (genvar k = 0; k < (1 << AW); k++) begin : g_tbl
    localparam logic [DW-1:0] TV = DW'(quarter_sample(k, AW + 2));
    assign rom_w[k] = TV;
  end

  // Registered read on both ports.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      data0_q <= rom_w[addr0_i];
      data1_q <= rom_w[addr1_i];
    end
  end

  assign data0_o = data0_q;
  assign data1_o = data1_q;

endmodule

// File: rtl/nco_coff_gen.sv
// Two-carrier NCO: per-sample sin/cos coefficients aligned with the forwarded I/Q stream.
module nco_coff_gen
  import nco_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = NCO_LUT_AW,
  parameter int COFF_W  = NCO_COFF_W,
  parameter int DATA_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [PHASE_W-1:0]       i_fcw_ca0,
  input  logic [PHASE_W-1:0]       i_fcw_ca1,
  input  logic                     i_cfg_update,
  input  logic                     i_sync,
  input  logic                     i_data_vld,
  input  logic                     i_data_ca,
  input  logic [DATA_W-1:0]        i_data_i,
  input  logic [DATA_W-1:0]        i_data_q,
  output logic                     o_data_vld,
  output logic                     o_data_ca,
  output logic [DATA_W-1:0]        o_data_i,
  output logic [DATA_W-1:0]        o_data_q,
  output logic [COFF_W-1:0]        o_sin_coff,
  output logic [COFF_W-1:0]        o_cos_coff
);

  localparam int QAW    = LUT_AW - 2;
  localparam int STAGES = 4;

  logic [1:0][PHASE_W-1:0] acc_q, acc_d, fcw_q, fcw_d;
  logic [PHASE_W-1:0]      phase_sel;

  logic [STAGES-1:0]             vld_pipe_q, ca_pipe_q;
  logic [STAGES-1:0][DATA_W-1:0] di_pipe_q, dq_pipe_q;

  logic [LUT_AW-1:0] ph1_q;
  logic [LUT_AW-1:0] sin_idx, cos_idx;
  logic [QAW-1:0]    saddr2_q, caddr2_q;
  logic              sneg2_q, cneg2_q, sneg3_q, cneg3_q;
  logic [COFF_W-1:0] srom3, crom3;
  logic [COFF_W-1:0] sin4_q, cos4_q;

  // Phase select and accumulator/FCW next state. The sample uses the pre-update
  // phase and the old FCW; sync forces phase 0 and overrides the normal increment.
  always_comb begin
    fcw_d     = fcw_q;
    acc_d     = acc_q;
    phase_sel = acc_q[i_data_ca];
    if (i_cfg_update) fcw_d = {i_fcw_ca1, i_fcw_ca0};
    if (i_sync) begin
      acc_d     = '0;
      phase_sel = '0;
    end
    if (i_data_vld) acc_d[i_data_ca] = phase_sel + fcw_q[i_data_ca];
  end

  // Carrier state registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      acc_q <= '0;
      fcw_q <= '0;
    end else begin
      acc_q <= acc_d;
      fcw_q <= fcw_d;
    end
  end

  // Sample side-band shifts alongside the coefficient path, valid or not.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      vld_pipe_q <= '0;
      ca_pipe_q  <= '0;
      di_pipe_q  <= '0;
      dq_pipe_q  <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-2:0], i_data_vld};
      ca_pipe_q  <= {ca_pipe_q[STAGES-2:0], i_data_ca};
      di_pipe_q  <= {di_pipe_q[STAGES-2:0], i_data_i};
      dq_pipe_q  <= {dq_pipe_q[STAGES-2:0], i_data_q};
    end
  end

  // Cos is sin advanced by one quadrant on the truncated lookup phase.
  assign sin_idx = ph1_q;
  assign cos_idx = ph1_q + LUT_AW'(1 << QAW);

  // S1 phase, S2 mirrored address + sign, S3 sign alongside ROM read.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ph1_q    <= '0;
      saddr2_q <= '0;
      caddr2_q <= '0;
      sneg2_q  <= 1'b0;
      cneg2_q  <= 1'b0;
      sneg3_q  <= 1'b0;
      cneg3_q  <= 1'b0;
    end else begin
      ph1_q    <= phase_sel[PHASE_W-1 -: LUT_AW];
      saddr2_q <= sin_idx[QAW-1:0] ^ {QAW{sin_idx[QAW + QUAD_MIRROR_BIT]}};
      caddr2_q <= cos_idx[QAW-1:0] ^ {QAW{cos_idx[QAW + QUAD_MIRROR_BIT]}};
      sneg2_q  <= sin_idx[QAW + QUAD_NEG_BIT];
      cneg2_q  <= cos_idx[QAW + QUAD_NEG_BIT];
      sneg3_q  <= sneg2_q;
      cneg3_q  <= cneg2_q;
    end
  end

  nco_quarter_rom #(
    .AW (QAW),
    .DW (COFF_W)
  ) u_rom (
    .clk_i   (i_clk),
    .rst_ni  (i_reset),
    .addr0_i (saddr2_q),
    .addr1_i (caddr2_q),
    .data0_o (srom3),
    .data1_o (crom3)
  );

  // S4 sign apply; table magnitude never exceeds 32767 so negation is exact.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sin4_q <= '0;
      cos4_q <= '0;
    end else begin
      sin4_q <= sneg3_q ? (COFF_W'(0) - srom3) : srom3;
      cos4_q <= cneg3_q ? (COFF_W'(0) - crom3) : crom3;
    end
  end

  assign o_data_vld = vld_pipe_q[STAGES-1];
  assign o_data_ca  = ca_pipe_q[STAGES-1];
  assign o_data_i   = di_pipe_q[STAGES-1];
  assign o_data_q   = dq_pipe_q[STAGES-1];
  assign o_sin_coff = sin4_q;
  assign o_cos_coff = cos4_q;

endmodule
